// File: rtl/mac_sequencer.sv
// mac_sequencer: drives one group_mac through a full dot-product pass.
// Flow: accept a length, clear the accumulators, stream that many beats,
// wait out the MAC pipeline, then hold the captured result until it is taken.
module mac_sequencer #(
    parameter int  GROUP_NB     = 4,
    parameter int  IMG_WIDTH    = 16,
    parameter int  KER_WIDTH    = 16,
    parameter int  LEN_WIDTH    = 16,
    parameter int  MAC_LATENCY  = 6,
    localparam int RESULT_WIDTH = IMG_WIDTH + KER_WIDTH + 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [LEN_WIDTH-1:0]             cfg_len,
    input  logic                             cfg_val,
    output logic                             cfg_rdy,
    input  logic [GROUP_NB*IMG_WIDTH-1:0]    img,
    input  logic [GROUP_NB*KER_WIDTH-1:0]    ker,
    input  logic                             in_val,
    output logic                             in_rdy,
    output logic [GROUP_NB*IMG_WIDTH-1:0]    mac_img,
    output logic [GROUP_NB*KER_WIDTH-1:0]    mac_ker,
    output logic                             mac_val,
    output logic                             mac_clr,
    input  logic [GROUP_NB*RESULT_WIDTH-1:0] mac_result,
    output logic [GROUP_NB*RESULT_WIDTH-1:0] result,
    output logic                             res_val,
    input  logic                             res_rdy,
    output logic                             busy
);

    localparam int DRAIN_WIDTH = $clog2(MAC_LATENCY + 1);
    localparam logic [DRAIN_WIDTH-1:0] DRAIN_LAST = DRAIN_WIDTH'(MAC_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        OUTPUT
    } state_t;

    state_t                           state_reg, state_next;
    logic [LEN_WIDTH-1:0]             len_reg, len_next;
    logic [LEN_WIDTH-1:0]             beat_cnt_reg, beat_cnt_next;
    logic [DRAIN_WIDTH-1:0]           drain_cnt_reg, drain_cnt_next;
    logic [GROUP_NB*RESULT_WIDTH-1:0] result_reg, result_next;

    // State, counters and captured result; reset aborts any pass in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            len_reg       <= '0;
            beat_cnt_reg  <= '0;
            drain_cnt_reg <= '0;
            result_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            len_reg       <= len_next;
            beat_cnt_reg  <= beat_cnt_next;
            drain_cnt_reg <= drain_cnt_next;
            result_reg    <= result_next;
        end
    end

    // Next-state logic; every register holds unless its state moves it.
    always_comb begin
        state_next     = state_reg;
        len_next       = len_reg;
        beat_cnt_next  = beat_cnt_reg;
        drain_cnt_next = drain_cnt_reg;
        result_next    = result_reg;
        case (state_reg)
            IDLE: begin
                if (cfg_val) begin
                    len_next      = cfg_len;
                    beat_cnt_next = '0;
                    state_next    = CLEAR;
                end
            end
            CLEAR: begin
                drain_cnt_next = '0;
                // A zero-length pass skips streaming and drains the cleared group.
                state_next     = (len_reg != '0) ? STREAM : DRAIN;
            end
            STREAM: begin
                if (in_val) begin
                    beat_cnt_next = beat_cnt_reg + LEN_WIDTH'(1);
                    // Compare against len-1 so a full-scale length never wraps the count.
                    if (beat_cnt_reg == len_reg - LEN_WIDTH'(1)) begin
                        drain_cnt_next = '0;
                        state_next     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_reg == DRAIN_LAST) begin
                    result_next    = mac_result;
                    drain_cnt_next = '0;
                    state_next     = OUTPUT;
                end else begin
                    drain_cnt_next = drain_cnt_reg + DRAIN_WIDTH'(1);
                end
            end
            OUTPUT: begin
                if (res_rdy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Beat data goes straight to the group; only the valid is qualified.
    for (genvar gi = 0; gi < GROUP_NB; gi++) begin : g_lane
        assign mac_img[gi*IMG_WIDTH +: IMG_WIDTH] = img[gi*IMG_WIDTH +: IMG_WIDTH];
        assign mac_ker[gi*KER_WIDTH +: KER_WIDTH] = ker[gi*KER_WIDTH +: KER_WIDTH];
    end

    assign cfg_rdy = (state_reg == IDLE);
    assign in_rdy  = (state_reg == STREAM);
    assign mac_val = in_val & in_rdy;
    // System reset also wipes the accumulators so an aborted pass leaves nothing behind.
    assign mac_clr = ~rst_n | (state_reg == CLEAR);
    assign res_val = (state_reg == OUTPUT);
    assign busy    = (state_reg != IDLE);
    assign result  = result_reg;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: a behavioural group_mac closes the loop, a table of
// passes covers the main flow, and hand-written sequences cover zero length
// and reset in the middle of a pass.
module tb_mac_sequencer;

    localparam int NB = 4;
    localparam int IW = 16;
    localparam int KW = 16;
    localparam int LW = 16;
    localparam int L  = 6;
    localparam int RW = IW + KW + 1;

    logic                clk;
    logic                rst_n;
    logic [LW-1:0]       cfg_len;
    logic                cfg_val;
    logic                cfg_rdy;
    logic [NB*IW-1:0]    img;
    logic [NB*KW-1:0]    ker;
    logic                in_val;
    logic                in_rdy;
    logic [NB*IW-1:0]    mac_img;
    logic [NB*KW-1:0]    mac_ker;
    logic                mac_val;
    logic                mac_clr;
    logic [NB*RW-1:0]    mac_result;
    logic [NB*RW-1:0]    result;
    logic                res_val;
    logic                res_rdy;
    logic                busy;

    mac_sequencer #(
        .GROUP_NB    (NB),
        .IMG_WIDTH   (IW),
        .KER_WIDTH   (KW),
        .LEN_WIDTH   (LW),
        .MAC_LATENCY (L)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_len    (cfg_len),
        .cfg_val    (cfg_val),
        .cfg_rdy    (cfg_rdy),
        .img        (img),
        .ker        (ker),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .mac_img    (mac_img),
        .mac_ker    (mac_ker),
        .mac_val    (mac_val),
        .mac_clr    (mac_clr),
        .mac_result (mac_result),
        .result     (result),
        .res_val    (res_val),
        .res_rdy    (res_rdy),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural group_mac: signed accumulate, result visible L cycles after mac_val.
    logic [NB-1:0][RW-1:0] acc;
    logic [NB-1:0][RW-1:0] pipe [L-1];
    assign mac_result = pipe[L-2];

    function automatic logic [RW-1:0] prod(input logic [IW-1:0] a, input logic [KW-1:0] b);
        logic signed [IW+KW-1:0] p;
        p = $signed(a) * $signed(b);
        return {p[IW+KW-1], p};
    endfunction

    always @(posedge clk) begin
        if (mac_clr) begin
            acc <= '0;
            for (int k = 0; k < L - 1; k++) pipe[k] <= '0;
        end else begin
            for (int k = L - 2; k > 0; k--) pipe[k] <= pipe[k-1];
            pipe[0] <= acc;
            if (mac_val) begin
                for (int l = 0; l < NB; l++)
                    acc[l] <= acc[l] + prod(mac_img[l*IW +: IW], mac_ker[l*KW +: KW]);
            end
        end
    end

    // Cycle index plus pulse counters for mac_val and mac_clr.
    int cyc = 0;
    int mac_val_cnt = 0;
    int mac_clr_cnt = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mac_val) mac_val_cnt <= mac_val_cnt + 1;
        if (mac_clr) mac_clr_cnt <= mac_clr_cnt + 1;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic [LW-1:0]         len;
        logic [NB-1:0][IW-1:0] img;
        logic [NB-1:0][KW-1:0] ker;
        logic                  gap;
        logic [7:0]            hold;
        logic                  inj;
        logic [NB-1:0][RW-1:0] exp;
    } vec_t;

    // One complete pass: configure, stream, wait for the result, hand it off.
    task automatic run_pass(input string tag, input vec_t v);
        int guard;
        int beats;
        bit tog;
        int s_cyc;
        int base;
        logic [NB*RW-1:0] cap;
        guard = 0;
        while (!cfg_rdy && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, ".cfg_rdy_before"}, cfg_rdy, 1);
        cfg_val = 1'b1;
        cfg_len = v.len;
        res_rdy = (v.hold == 0);
        img     = v.img;
        ker     = v.ker;
        base    = mac_val_cnt;
        beats   = 0;
        tog     = 1'b0;
        s_cyc   = cyc;
        guard   = 0;
        while (beats < int'(v.len) && guard < 200) begin
            @(negedge clk);
            guard++;
            cfg_val = 1'b0;
            in_val  = 1'b0;
            if (v.inj) begin
                chk({tag, ".cfg_rdy_low"}, cfg_rdy, 0);
                if (beats == 1) begin
                    cfg_val = 1'b1;
                    cfg_len = 16'd9;
                end
            end
            if (in_rdy) begin
                in_val = v.gap ? !tog : 1'b1;
                tog    = !tog;
                if (in_val) begin
                    beats++;
                    s_cyc = cyc;
                end
            end
        end
        chk({tag, ".beats"}, beats, v.len);
        @(negedge clk);
        cfg_val = 1'b0;
        in_val  = 1'b0;
        chk({tag, ".in_rdy_after_last"}, in_rdy, 0);
        guard = 0;
        while (!res_val && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, ".res_latency"}, cyc - s_cyc, L + 1);
        for (int l = 0; l < NB; l++)
            chk($sformatf("%s.lane%0d", tag, l), result[l*RW +: RW], v.exp[l]);
        cap = result;
        if (v.hold > 0) begin
            for (int i = 0; i < int'(v.hold); i++) begin
                chk({tag, ".res_val_held"}, res_val, 1);
                chk({tag, ".result_stable"}, result == cap, 1);
                if (i == int'(v.hold) - 1) res_rdy = 1'b1;
                @(negedge clk);
            end
        end else begin
            @(negedge clk);
        end
        chk({tag, ".idle_after_handshake"}, {cfg_rdy, busy, res_val}, 3'b100);
        chk({tag, ".mac_val_pulses"}, mac_val_cnt - base, v.len);
    endtask

    vec_t vecs [5];
    vec_t follow;

    // Main sequence: reset, table of passes, then the multi-cycle corner cases.
    initial begin
        int t;
        int guard;
        int beats;
        int base;
        int clr_base;
        bit seen;

        vecs[0] = '{len: 16'd3, img: {16'd4, 16'd3, 16'd2, 16'd1}, ker: {4{16'd2}},
                    gap: 1'b0, hold: 8'd0, inj: 1'b0, exp: {33'd24, 33'd18, 33'd12, 33'd6}};
        vecs[1] = '{len: 16'd4, img: {16'd4, 16'd3, 16'd2, 16'd1},
                    ker: {16'd5, 16'hFFFE, 16'd3, 16'd1},
                    gap: 1'b1, hold: 8'd5, inj: 1'b0,
                    exp: {33'd80, 33'h1FFFFFFE8, 33'd24, 33'd4}};
        vecs[2] = '{len: 16'd2, img: {4{16'd1}}, ker: {4{16'd1}},
                    gap: 1'b0, hold: 8'd0, inj: 1'b0, exp: {4{33'd2}}};
        vecs[3] = '{len: 16'd1, img: {4{16'd3}}, ker: {4{16'hFFFF}},
                    gap: 1'b0, hold: 8'd0, inj: 1'b0, exp: {4{33'h1FFFFFFFD}}};
        vecs[4] = '{len: 16'd2, img: {16'd7, 16'd6, 16'd5, 16'd4}, ker: {4{16'd1}},
                    gap: 1'b0, hold: 8'd0, inj: 1'b1, exp: {33'd14, 33'd12, 33'd10, 33'd8}};
        follow  = '{len: 16'd1, img: {4{16'd2}}, ker: {4{16'd2}},
                    gap: 1'b0, hold: 8'd0, inj: 1'b0, exp: {4{33'd4}}};

        rst_n   = 1'b0;
        cfg_len = '0;
        cfg_val = 1'b0;
        img     = '0;
        ker     = '0;
        in_val  = 1'b0;
        res_rdy = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset.outputs_in_reset", {cfg_rdy, in_rdy, mac_val, mac_clr, res_val, busy}, 6'b100101 & 6'b100100 | 6'b000100);
        chk("reset.result_zero", result == '0, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset.outputs_after", {cfg_rdy, in_rdy, mac_val, mac_clr, res_val, busy}, 6'b100000);

        for (int i = 0; i < 5; i++)
            run_pass($sformatf("vec%0d", i), vecs[i]);

        // Zero length: one clear pulse, no beats, all-zero result at t+2+L.
        clr_base = mac_clr_cnt;
        base     = mac_val_cnt;
        cfg_val  = 1'b1;
        cfg_len  = '0;
        res_rdy  = 1'b1;
        t        = cyc;
        @(negedge clk);
        cfg_val = 1'b0;
        guard   = 0;
        while (!res_val && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("zero.res_latency", cyc - t, L + 2);
        chk("zero.result_zero", result == '0, 1);
        chk("zero.mac_clr_pulses", mac_clr_cnt - clr_base, 1);
        chk("zero.mac_val_pulses", mac_val_cnt - base, 0);
        @(negedge clk);
        chk("zero.idle_after", {cfg_rdy, busy, res_val}, 3'b100);

        // Reset after 2 of 5 beats: pass is dropped and never reports.
        cfg_val = 1'b1;
        cfg_len = 16'd5;
        img     = {4{16'd5}};
        ker     = {4{16'd7}};
        beats   = 0;
        guard   = 0;
        while (beats < 2 && guard < 50) begin
            @(negedge clk);
            guard++;
            cfg_val = 1'b0;
            in_val  = 1'b0;
            if (in_rdy) begin
                in_val = 1'b1;
                beats++;
            end
        end
        @(negedge clk);
        in_val = 1'b0;
        rst_n  = 1'b0;
        @(negedge clk);
        chk("rst_mid.in_reset", {cfg_rdy, busy, mac_clr}, 3'b101);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid.idle", {cfg_rdy, in_rdy, busy, mac_clr}, 4'b1000);
        seen = 1'b0;
        for (int i = 0; i < L + 10; i++) begin
            if (res_val) seen = 1'b1;
            @(negedge clk);
        end
        chk("rst_mid.no_res_val", seen, 0);
        run_pass("rst_follow", follow);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mac_sequencer.md
# mac_sequencer

Control block that sequences one `group_mac` through complete dot-product passes. It accepts a per-pass length configuration, clears the MAC accumulators, and streams exactly that many image/kernel beats into the group. It then waits out the MAC pipeline latency and holds the captured result bus until downstream accepts it. It sits between the line-buffer/kernel-fetch stream and `group_mac`, and it owns the group's reset and valid lines.

## Interface
Parameters:
- `GROUP_NB`, 4: number of MACs in the controlled group.
- `IMG_WIDTH`, 16: image value width per MAC.
- `KER_WIDTH`, 16: kernel value width per MAC.
- `LEN_WIDTH`, 16: width of the beat-count configuration.
- `MAC_LATENCY`, 6: cycles from `mac_val` high to the corresponding `mac_result` update. Must be ≥1.
- `RESULT_WIDTH` (localparam): `IMG_WIDTH+KER_WIDTH+1`.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `cfg_len` in `LEN_WIDTH`: number of beats in the next pass.
- `cfg_val` in 1: config valid.
- `cfg_rdy` out 1: config ready; high only in IDLE.
- `img` in `GROUP_NB*IMG_WIDTH`: upstream image beat.
- `ker` in `GROUP_NB*KER_WIDTH`: upstream kernel beat.
- `in_val` in 1: upstream beat valid.
- `in_rdy` out 1: beat ready; high only in STREAM.
- `mac_img` out `GROUP_NB*IMG_WIDTH`: to `group_mac.img`.
- `mac_ker` out `GROUP_NB*KER_WIDTH`: to `group_mac.ker`.
- `mac_val` out 1: to `group_mac.val`.
- `mac_clr` out 1: to `group_mac.rst`; active-high accumulator clear.
- `mac_result` in `GROUP_NB*RESULT_WIDTH`: from `group_mac.result`.
- `result` out `GROUP_NB*RESULT_WIDTH`: captured pass result.
- `res_val` out 1: result valid.
- `res_rdy` in 1: downstream ready.
- `busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, OUTPUT.
- IDLE → CLEAR:
  - Taken on `cfg_val & cfg_rdy`.
  - `cfg_len` is latched into `len_r`, and the beat counter is zeroed.
- CLEAR:
  - `mac_clr=1` for exactly one cycle.
  - Goes to STREAM if `len_r≠0`, else to DRAIN. A zero-length pass yields an all-zero result.
- STREAM:
  - `in_rdy=1`.
  - `mac_val = in_val & in_rdy`.
  - `mac_img`/`mac_ker` are combinational pass-through of `img`/`ker`; their value is don't-care when `mac_val=0`.
  - Each accepted beat increments the counter. The beat that makes the count equal `len_r` moves the FSM to DRAIN.
  - Gaps (`in_val=0`) are allowed; they stall the counter and issue no `mac_val`.
- DRAIN:
  - The drain counter runs for `MAC_LATENCY` cycles.
  - In the final DRAIN cycle, `result <= mac_result`; the FSM then enters OUTPUT.
- OUTPUT:
  - `res_val=1` and `result` is held stable.
  - On `res_val & res_rdy`, the FSM goes to IDLE.
  - `cfg_rdy` stays low until IDLE, so back-to-back passes have one IDLE cycle between them.
- `mac_clr = ~rst_n | (state==CLEAR)`: system reset also clears the group.
- Counter widths:
  - Beat counter is `LEN_WIDTH` bits; `len_r` up to `2^LEN_WIDTH-1` is legal, with no wrap.
  - Drain counter is `$clog2(MAC_LATENCY+1)` bits.

## Timing
- Reset (`rst_n=0` at an edge) takes effect from the next cycle:
  - FSM is in IDLE.
  - `cfg_rdy=1`, `in_rdy=0`, `mac_val=0`, `mac_clr=0` (1 while `rst_n=0`), `res_val=0`, `busy=0`, `result=0`.
  - Both counters are 0.
- Reset mid-pass (any state) aborts the pass.
  - No `res_val` is produced for it.
  - The accumulators are cleared via `mac_clr`.
- Config accepted in cycle t:
  - CLEAR in t+1.
  - `in_rdy=1` from t+2.
- Last beat accepted in cycle s:
  - `in_rdy=0` from s+1.
  - `result` capture at the end of cycle s+`MAC_LATENCY`.
  - `res_val=1` from s+`MAC_LATENCY`+1.
- Zero length, config accepted at t: `res_val=1` from t+2+`MAC_LATENCY`.
- `res_rdy` may be high before `res_val`. If it is, the handshake completes in the first OUTPUT cycle.
- `cfg_val` during a non-IDLE state is ignored and not latched.
- `in_val` is ignored outside STREAM.

## Test plan
- Single pass:
  - Stimulus: `GROUP_NB=4`, `cfg_len=3`, beats img={1,2,3,4}, ker={2,2,2,2} ×3, `res_rdy=1`.
  - Expect: `result` lanes {6,12,18,24}; `res_val` exactly `MAC_LATENCY`+1 cycles after the 3rd beat; exactly 3 `mac_val` pulses.
- Bubbles and backpressure:
  - Stimulus: `cfg_len=4` with `in_val` toggling 1,0,1,0,…; `res_rdy` held low 5 cycles after `res_val`.
  - Expect: 4 `mac_val` pulses; `result` stable and `res_val` held for all 5 cycles; IDLE one cycle after `res_rdy`.
- Zero length:
  - Stimulus: `cfg_len=0`, config at t.
  - Expect: one `mac_clr` pulse; no `mac_val`; `res_val` at t+2+`MAC_LATENCY` with `result=0`.
- Back-to-back passes:
  - Stimulus: pass A with img=ker=1 ×2, then pass B with img=3, ker=−1 ×1.
  - Expect: A lanes=2; B lanes=−3, i.e. no carry-over from A, proving `mac_clr`.
- Reset mid-stream:
  - Stimulus: drop `rst_n` after 2 of 5 beats.
  - Expect: IDLE; `res_val` never rises for that pass; a following `cfg_len=1` pass with img=ker=2 gives lanes=4.
- Ignored config:
  - Stimulus: pulse `cfg_val` with `cfg_len=9` during STREAM of a `cfg_len=2` pass.
  - Expect: exactly 2 beats consumed; `cfg_rdy=0` throughout.
